// File: rtl/tmds_decoder_dvi.sv
// rtl/tmds_decoder_dvi.sv - TMDS channel decoder with control-token word alignment
// Alignment FSM, run counter and timeout counter exist only with TMDS_DECODER_ALIGN_EN defined.
module tmds_decoder_dvi #(
    parameter int MIN_RUN        = 8,
    parameter int LOCK_RUNS      = 4,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [9:0] i_tmds,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_bitslip,
    output logic       o_aligned
);

    logic [9:0] tmds_q;
    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d;
    logic       is_ctrl;
    logic [1:0] ctrl_sym;
    logic [7:0] qp;
    logic [7:0] dec;

    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_sym = 2'b00;
        case (tmds_q)
            10'b1101010100: ctrl_sym = 2'b00;
            10'b0010101011: ctrl_sym = 2'b01;
            10'b0101010100: ctrl_sym = 2'b10;
            10'b1010101011: ctrl_sym = 2'b11;
            default:        is_ctrl  = 1'b0;
        endcase
        qp     = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
        dec    = 8'h00;
        dec[0] = qp[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = tmds_q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
        end
        data_d = is_ctrl ? 8'h00 : dec;
        ctrl_d = is_ctrl ? ctrl_sym : ctrl_q;
        de_d   = ~is_ctrl;
    end

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            tmds_q <= '0;
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else begin
            tmds_q <= i_tmds;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
        end
    end

    assign o_data = data_q;
    assign o_ctrl = ctrl_q;
    assign o_de   = de_q;

`ifdef TMDS_DECODER_ALIGN_EN
    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    localparam int RW = $clog2(MIN_RUN + 1);
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_RUNS + 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MIN_RUN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(MIN_RUN - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(SEARCH_TIMEOUT);
    localparam logic [TW-1:0] SLIP_LAST = TW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_RUNS - 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   run_q, run_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [LW-1:0]   tally_q, tally_d;
    logic            bitslip_q, bitslip_d;
    logic            aligned_q, aligned_d;
    logic            valid_run;
    logic            timeout;

    // Fires only on the token that brings the counter up to MIN_RUN; saturation keeps it one-shot.
    assign valid_run = (state_q != ST_SLIP) && is_ctrl && (run_q == RUN_LAST);
    assign timeout   = (tmo_q == TMO_MAX);

    always_comb begin
        state_d   = state_q;
        tally_d   = tally_q;
        bitslip_d = 1'b0;
        tmo_d     = tmo_q + 1'b1;
        if (state_q == ST_SLIP || !is_ctrl) begin
            run_d = '0;
        end else if (run_q == RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 1'b1;
        end
        case (state_q)
            ST_SEARCH: begin
                if (valid_run) begin
                    state_d = ST_VERIFY;
                    tally_d = LW'(1);
                end else if (timeout) begin
                    bitslip_d = 1'b1;
                    state_d   = ST_SLIP;
                end
            end
            ST_SLIP: begin
                if (tmo_q == SLIP_LAST) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (valid_run) begin
                    tally_d = tally_q + 1'b1;
                    if (tally_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                    end
                end else if (timeout) begin
                    bitslip_d = 1'b1;
                    state_d   = ST_SLIP;
                end
            end
            ST_LOCKED: begin
                if (timeout && !valid_run) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        if (valid_run || (state_d != state_q)) begin
            tmo_d = '0;
        end
        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            tmo_q     <= '0;
            tally_q   <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            tmo_q     <= tmo_d;
            tally_q   <= tally_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
        end
    end

    assign o_bitslip = bitslip_q;
    assign o_aligned = aligned_q;
`else
    logic aligned_q;
    logic unused_params;

    // Without alignment the word boundary is assumed correct from the first clock after reset.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            aligned_q <= 1'b0;
        end else begin
            aligned_q <= 1'b1;
        end
    end

    assign unused_params = ^{MIN_RUN, LOCK_RUNS, SEARCH_TIMEOUT, SLIP_WAIT};
    assign o_bitslip     = 1'b0;
    assign o_aligned     = aligned_q;
`endif

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// tb/tb_tmds_decoder_dvi.sv - directed self-checking bench for tmds_decoder_dvi
module tb_tmds_decoder_dvi;

    localparam int MR   = 8;
    localparam int LR   = 4;
    localparam int TO   = 64;
    localparam int SW   = 16;
    localparam int RUNL = 12;
    localparam int LINE = 52;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] tmds;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       bitslip;
    logic       aligned;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int bs_cnt = 0;
    int bs_cyc [8];
    int k   = 0;
    int off = 0;

    tmds_decoder_dvi #(
        .MIN_RUN(MR),
        .LOCK_RUNS(LR),
        .SEARCH_TIMEOUT(TO),
        .SLIP_WAIT(SW)
    ) dut (
        .i_pix_clk(clk),
        .i_rst(rst),
        .i_tmds(tmds),
        .o_data(data),
        .o_ctrl(ctrl),
        .o_de(de),
        .o_bitslip(bitslip),
        .o_aligned(aligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bitslip) begin
            if (bs_cnt < 8) bs_cyc[bs_cnt] = cyc;
            bs_cnt = bs_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_const(input logic [9:0] sym, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tmds = sym;
        end
    endtask

    task automatic async_reset_check(input logic [1:0] pre_ctrl);
        check_eq("pre_rst_de", 32'(de), 32'd1);
        check_eq("pre_rst_data", 32'(data), 32'h55);
        check_eq("pre_rst_ctrl", 32'(ctrl), 32'(pre_ctrl));
        #3 rst = 1'b1;
        #1;
        check_eq("rst_async_data", 32'(data), 32'h0);
        check_eq("rst_async_ctrl", 32'(ctrl), 32'h0);
        check_eq("rst_async_de", 32'(de), 32'h0);
        check_eq("rst_async_aligned", 32'(aligned), 32'h0);
        check_eq("rst_async_bitslip", 32'(bitslip), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef TMDS_DECODER_ALIGN_EN
    function automatic logic [9:0] sym_at(input int idx);
        if ((idx % LINE) < RUNL) return 10'h0AB;
        return 10'h133;
    endfunction

    function automatic logic [9:0] word_at(input int kk, input int oo);
        logic [9:0] w;
        logic [9:0] s;
        int p;
        w = '0;
        for (int j = 0; j < 10; j++) begin
            p    = oo + j;
            s    = sym_at(kk + p / 10);
            w[j] = s[p % 10];
        end
        return w;
    endfunction

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bitslip) begin
                off = off + 1;
                if (off == 10) begin
                    off = 0;
                    k   = k + 1;
                end
            end
            tmds = word_at(k, off);
            k    = k + 1;
        end
    endtask

    task automatic pulse_reset(input int start_off);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        off = start_off;
    endtask
`endif

    logic [9:0] sym_tab [9] = '{10'h100, 10'h3FF, 10'h133, 10'h3CC, 10'h037,
                                10'h2C8, 10'h0FF, 10'h200, 10'h155};
    logic [7:0] exp_tab [9] = '{8'h00, 8'h00, 8'h55, 8'h55, 8'hA7,
                                8'hA7, 8'hFF, 8'hFF, 8'hFF};
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    initial begin
        logic [7:0] prev;
        int bs0;
        int found;
        rst  = 1'b1;
        tmds = 10'h000;
        repeat (3) @(negedge clk);
        check_eq("reset_data", 32'(data), 32'h0);
        check_eq("reset_ctrl", 32'(ctrl), 32'h0);
        check_eq("reset_de", 32'(de), 32'h0);
        check_eq("reset_bitslip", 32'(bitslip), 32'h0);
        check_eq("reset_aligned", 32'(aligned), 32'h0);
        rst = 1'b0;
        @(negedge clk);
`ifdef TMDS_DECODER_ALIGN_EN
        check_eq("aligned_after_release", 32'(aligned), 32'h0);
`else
        check_eq("aligned_one_clock", 32'(aligned), 32'h1);
`endif
        @(negedge clk);

        // 0x000 decodes to 0xFE, which is what the outputs show going in
        prev = 8'hFE;
        for (int i = 0; i < 9; i++) begin
            tmds = sym_tab[i];
            @(negedge clk);
            check_eq($sformatf("lat_hold_%0d", i), 32'(data), 32'(prev));
            @(negedge clk);
            check_eq($sformatf("dec_data_%0d", i), 32'(data), 32'(exp_tab[i]));
            check_eq($sformatf("dec_de_%0d", i), 32'(de), 32'h1);
            prev = exp_tab[i];
        end

        for (int i = 0; i < 4; i++) begin
            tmds = tok_tab[i];
            repeat (2) @(negedge clk);
            check_eq($sformatf("tok_ctrl_%0d", i), 32'(ctrl), 32'(i));
            check_eq($sformatf("tok_de_%0d", i), 32'(de), 32'h0);
            check_eq($sformatf("tok_data_%0d", i), 32'(data), 32'h0);
        end
        tmds = 10'h133;
        repeat (2) @(negedge clk);
        check_eq("ctrl_hold", 32'(ctrl), 32'h3);
        check_eq("ctrl_hold_de", 32'(de), 32'h1);

`ifdef TMDS_DECODER_ALIGN_EN
        pulse_reset(0);
        bs0 = bs_cnt;
        stream(3 * LINE + 4);
        check_eq("lock_after_3_runs", 32'(aligned), 32'h0);
        stream(10);
        check_eq("lock_after_4_runs", 32'(aligned), 32'h1);
        stream(LINE - 14);
        check_eq("lock_stays", 32'(aligned), 32'h1);
        check_eq("lock_no_slip", 32'(bs_cnt - bs0), 32'h0);

        drive_const(10'h133, 10);
        check_eq("loss_hold", 32'(aligned), 32'h1);
        drive_const(10'h133, 30);
        check_eq("loss_drop", 32'(aligned), 32'h0);
        check_eq("loss_no_slip", 32'(bs_cnt - bs0), 32'h0);
        stream(3 * LINE);
        check_eq("relock_early", 32'(aligned), 32'h0);
        stream(14);
        check_eq("relock", 32'(aligned), 32'h1);
        check_eq("relock_no_slip", 32'(bs_cnt - bs0), 32'h0);

        pulse_reset(0);
        stream(2 * LINE + 16);
        check_eq("verify_not_locked", 32'(aligned), 32'h0);
        async_reset_check(2'b01);
        k   = 0;
        off = 7;
        bs0 = bs_cnt;
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            stream(1);
            if (aligned) found = 1;
        end
        check_eq("mis_lock", 32'(found), 32'h1);
        check_eq("mis_slips", 32'(bs_cnt - bs0), 32'h3);
        if (bs_cnt - bs0 == 3) begin
            for (int i = 1; i < 3; i++) begin
                check_eq($sformatf("mis_gap_%0d", i),
                         32'(bs_cyc[bs0 + i] - bs_cyc[bs0 + i - 1] >= TO + SW), 32'h1);
            end
        end
`else
        async_reset_check(2'b11);
        check_eq("release_aligned_low", 32'(aligned), 32'h0);
        @(negedge clk);
        check_eq("release_aligned_high", 32'(aligned), 32'h1);
        drive_const(10'h0AB, 20);
        check_eq("bitslip_never", 32'(bs_cnt), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
